// File: rtl/sdrc_req_gen_mp_if.sv
// Request bus of the multi-page SDRAM request generator: application request
// side plus the chunk interface towards bank_ctl / xfr_ctl.
interface sdrc_req_gen_mp_if #(
  parameter int APP_AW = 26,
  parameter int APP_RW = 9,
  parameter int ID_W   = 4,
  parameter int BA_W   = 2,
  parameter int RA_W   = 13,
  parameter int CA_W   = 13,
  parameter int LEN_W  = APP_RW + 2
);
  logic              req;
  logic [ID_W-1:0]   req_id;
  logic [APP_AW-1:0] req_addr;
  logic [APP_RW-1:0] req_len;
  logic              req_wr_n;
  logic              req_wrap;
  logic              req_ack;
  logic              r2x_idle;
  logic              r2b_req;
  logic [ID_W-1:0]   r2b_req_id;
  logic              r2b_start;
  logic              r2b_last;
  logic              r2b_wrap;
  logic              r2b_write;
  logic [BA_W-1:0]   r2b_ba;
  logic [RA_W-1:0]   r2b_raddr;
  logic [CA_W-1:0]   r2b_caddr;
  logic [LEN_W-1:0]  r2b_len;
  logic              b2r_ack;
  logic              b2r_arb_ok;

  modport master (
    output req, req_id, req_addr, req_len, req_wr_n, req_wrap, b2r_ack, b2r_arb_ok,
    input  req_ack, r2x_idle, r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap,
           r2b_write, r2b_ba, r2b_raddr, r2b_caddr, r2b_len
  );

  modport slave (
    input  req, req_id, req_addr, req_len, req_wr_n, req_wrap, b2r_ack, b2r_arb_ok,
    output req_ack, r2x_idle, r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap,
           r2b_write, r2b_ba, r2b_raddr, r2b_caddr, r2b_len
  );
endinterface

// File: rtl/sdrc_req_gen_mp.sv
// Multi-page SDRAM request generator: scales an application burst to the SDRAM
// width and issues it to bank_ctl as page-bounded chunks (or one chunk on wrap).
module sdrc_req_gen_mp #(
  parameter int APP_AW = 26,
  parameter int APP_RW = 9,
  parameter int ID_W   = 4,
  parameter int BA_W   = 2,
  parameter int RA_W   = 13,
  parameter int CA_W   = 13
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  cfg_colbits,
  input  logic        cfg_map,
  input  logic [1:0]  sdr_width,
  sdrc_req_gen_mp_if.slave bus
);
  localparam int LEN_W = APP_RW + 2;
  // page space reaches 2048, so chunk arithmetic needs at least 12 bits
  localparam int SW    = (LEN_W > 12) ? LEN_W : 12;

  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e state_q, state_d;

  logic [ID_W-1:0]   id_q;
  logic              write_q, wrap_q, start_q, last_q;
  logic [APP_AW-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q, len_q;
  logic [BA_W-1:0]   ba_q;
  logic [RA_W-1:0]   row_q;
  logic [CA_W-1:0]   col_q;

  logic              ld, ack, wrap_d, start_d;
  logic [APP_AW-1:0] addr_d;
  logic [LEN_W-1:0]  rem_d, len_int;

  always_comb begin
    case (sdr_width)
      2'b00:   len_int = {2'b00, bus.req_len};
      2'b01:   len_int = {1'b0, bus.req_len, 1'b0};
      default: len_int = {bus.req_len, 2'b00};
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ld           = 1'b0;
    ack          = 1'b0;
    addr_d       = addr_q;
    rem_d        = rem_q;
    wrap_d       = wrap_q;
    start_d      = 1'b0;
    bus.r2x_idle = 1'b0;
    case (state_q)
      IDLE: begin
        ack          = bus.req & bus.b2r_arb_ok;
        bus.r2x_idle = ~bus.req;
        // zero-length bursts are acked and dropped
        if (ack && len_int != '0) begin
          ld      = 1'b1;
          addr_d  = bus.req_addr;
          rem_d   = len_int;
          wrap_d  = bus.req_wrap;
          start_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.b2r_ack) begin
          if (last_q) state_d = IDLE;
          else begin
            ld     = 1'b1;
            addr_d = addr_q + APP_AW'(len_q);
            rem_d  = rem_q - len_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ack = ack;

  // Chunk fields for whatever address/remaining is about to be loaded
  logic [3:0]        cbits;
  logic [APP_AW-1:0] pmask, col_a, sh;
  logic [SW-1:0]     space, rem_x, cl_x;
  logic [LEN_W-1:0]  c_len;
  logic              c_last;
  logic [BA_W-1:0]   c_ba;
  logic [RA_W-1:0]   c_row;
  logic [CA_W-1:0]   c_col;

  always_comb begin
    cbits  = 4'd8 + {2'b00, cfg_colbits};
    pmask  = (APP_AW'(1) << cbits) - APP_AW'(1);
    col_a  = addr_d & pmask;
    space  = (SW'(1) << cbits) - SW'(col_a);
    rem_x  = SW'(rem_d);
    cl_x   = (wrap_d || rem_x <= space) ? rem_x : space;
    c_len  = cl_x[LEN_W-1:0];
    c_last = (cl_x == rem_x);
    c_col  = CA_W'(col_a);
    sh     = addr_d >> cbits;
    if (!cfg_map) begin
      c_ba  = BA_W'(sh);
      c_row = RA_W'(sh >> BA_W);
    end else begin
      c_ba  = addr_d[APP_AW-1 -: BA_W];
      c_row = RA_W'({{BA_W{1'b0}}, addr_d[APP_AW-BA_W-1:0]} >> cbits);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      write_q <= 1'b0;
      wrap_q  <= 1'b0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ld) begin
        addr_q  <= addr_d;
        rem_q   <= rem_d;
        wrap_q  <= wrap_d;
        start_q <= start_d;
        len_q   <= c_len;
        last_q  <= c_last;
        ba_q    <= c_ba;
        row_q   <= c_row;
        col_q   <= c_col;
      end
      if (ld && state_q == IDLE) begin
        id_q    <= bus.req_id;
        write_q <= ~bus.req_wr_n;
      end
    end
  end

  assign bus.r2b_req    = (state_q == ACTIVE);
  assign bus.r2b_req_id = id_q;
  assign bus.r2b_start  = start_q;
  assign bus.r2b_last   = last_q;
  assign bus.r2b_wrap   = wrap_q;
  assign bus.r2b_write  = write_q;
  assign bus.r2b_ba     = ba_q;
  assign bus.r2b_raddr  = row_q;
  assign bus.r2b_caddr  = col_q;
  assign bus.r2b_len    = len_q;
endmodule

// File: tb/tb_sdrc_req_gen_mp.sv
// Directed bench for sdrc_req_gen_mp: page splitting, wrap, both address maps,
// arbitration stall, zero-length drop and mid-burst reset.
module tb_sdrc_req_gen_mp;
  logic       clk;
  logic       reset_n;
  logic [1:0] cfg_colbits;
  logic       cfg_map;
  logic [1:0] sdr_width;
  int         errs, checks;

  sdrc_req_gen_mp_if bus ();

  sdrc_req_gen_mp dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_colbits (cfg_colbits),
    .cfg_map     (cfg_map),
    .sdr_width   (sdr_width),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input string tag, input logic [25:0] addr, input logic [8:0] len,
                           input logic wr_n, input logic wrap, input logic [3:0] id);
    @(negedge clk);
    bus.req        = 1'b1;
    bus.req_addr   = addr;
    bus.req_len    = len;
    bus.req_wr_n   = wr_n;
    bus.req_wrap   = wrap;
    bus.req_id     = id;
    bus.b2r_arb_ok = 1'b1;
    #1 chk({tag, ".req_ack"}, 32'(bus.req_ack), 32'd1);
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  // Called one step after a clock edge; checks the presented chunk, then acks it
  task automatic chunk(input string tag, input logic [1:0] ba, input logic [12:0] row,
                       input logic [12:0] col, input logic [10:0] len,
                       input logic start, input logic last);
    chk({tag, ".req"},   32'(bus.r2b_req),   32'd1);
    chk({tag, ".ba"},    32'(bus.r2b_ba),    32'(ba));
    chk({tag, ".row"},   32'(bus.r2b_raddr), 32'(row));
    chk({tag, ".col"},   32'(bus.r2b_caddr), 32'(col));
    chk({tag, ".len"},   32'(bus.r2b_len),   32'(len));
    chk({tag, ".start"}, 32'(bus.r2b_start), 32'(start));
    chk({tag, ".last"},  32'(bus.r2b_last),  32'(last));
    bus.b2r_ack = 1'b1;
    @(posedge clk);
    #1 bus.b2r_ack = 1'b0;
  endtask

  task automatic done_chk(input string tag);
    chk({tag, ".req_off"}, 32'(bus.r2b_req),  32'd0);
    chk({tag, ".idle"},    32'(bus.r2x_idle), 32'd1);
  endtask

  initial begin
    errs = 0; checks = 0;
    reset_n = 1'b0;
    cfg_colbits = 2'b00; cfg_map = 1'b0; sdr_width = 2'b00;
    bus.req = 1'b0; bus.req_id = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.req_wr_n = 1'b1; bus.req_wrap = 1'b0; bus.b2r_ack = 1'b0; bus.b2r_arb_ok = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req",  32'(bus.r2b_req),  32'd0);
    chk("rst.len",  32'(bus.r2b_len),  32'd0);
    chk("rst.col",  32'(bus.r2b_caddr), 32'd0);
    chk("rst.idle", 32'(bus.r2x_idle), 32'd1);
    reset_n = 1'b1;

    // 1: fits in page
    start_req("t1", 26'h0F0, 9'd16, 1'b1, 1'b0, 4'h1);
    chk("t1.id", 32'(bus.r2b_req_id), 32'h1);
    chk("t1.write", 32'(bus.r2b_write), 32'd0);
    chunk("t1", 2'd0, 13'd0, 13'h0F0, 11'd16, 1'b1, 1'b1);
    done_chk("t1");

    // 2: two chunks across a page boundary
    start_req("t2", 26'h0F8, 9'd16, 1'b1, 1'b0, 4'h2);
    chunk("t2c1", 2'd0, 13'd0, 13'h0F8, 11'd8, 1'b1, 1'b0);
    chunk("t2c2", 2'd1, 13'd0, 13'h000, 11'd8, 1'b0, 1'b1);
    done_chk("t2");

    // 3: 8-bit width, len 100 -> 400, three chunks, write
    sdr_width = 2'b10;
    start_req("t3", 26'h0C0, 9'd100, 1'b0, 1'b0, 4'h3);
    chk("t3.write", 32'(bus.r2b_write), 32'd1);
    chk("t3.id", 32'(bus.r2b_req_id), 32'h3);
    chunk("t3c1", 2'd0, 13'd0, 13'h0C0, 11'd64,  1'b1, 1'b0);
    chunk("t3c2", 2'd1, 13'd0, 13'h000, 11'd256, 1'b0, 1'b0);
    chunk("t3c3", 2'd2, 13'd0, 13'h000, 11'd80,  1'b0, 1'b1);
    done_chk("t3");

    // 4: wrap keeps a single chunk
    sdr_width = 2'b00;
    start_req("t4", 26'h0F8, 9'd16, 1'b1, 1'b1, 4'h4);
    chk("t4.wrap", 32'(bus.r2b_wrap), 32'd1);
    chunk("t4", 2'd0, 13'd0, 13'h0F8, 11'd16, 1'b1, 1'b1);
    done_chk("t4");

    // row-bank-col row extraction: 0x12345, C=8 -> ba=3, row=0x48, col=0x45
    start_req("t4b", 26'h0012345, 9'd4, 1'b1, 1'b0, 4'h5);
    chunk("t4b", 2'd3, 13'h048, 13'h045, 11'd4, 1'b1, 1'b1);
    done_chk("t4b");

    // 5: bank-row-col mapping, 9 column bits
    cfg_map = 1'b1; cfg_colbits = 2'b01;
    start_req("t5", 26'h3000040, 9'd4, 1'b1, 1'b0, 4'h6);
    chunk("t5", 2'd3, 13'd0, 13'h040, 11'd4, 1'b1, 1'b1);
    done_chk("t5");
    cfg_map = 1'b0; cfg_colbits = 2'b00;

    // 6a: no arbitration grant
    @(negedge clk);
    bus.req = 1'b1; bus.req_len = 9'd4; bus.req_addr = 26'h0; bus.b2r_arb_ok = 1'b0;
    #1 chk("t6a.req_ack", 32'(bus.req_ack), 32'd0);
    chk("t6a.idle", 32'(bus.r2x_idle), 32'd0);
    @(posedge clk);
    #1 chk("t6a.r2b_req", 32'(bus.r2b_req), 32'd0);
    bus.req = 1'b0;

    // 6b: zero-length request is acked and dropped
    start_req("t6b", 26'h010, 9'd0, 1'b1, 1'b0, 4'h7);
    chk("t6b.r2b_req", 32'(bus.r2b_req), 32'd0);
    @(posedge clk);
    #1 chk("t6b.r2b_req2", 32'(bus.r2b_req), 32'd0);

    // 6c: reset during chunk2 of the test-3 burst
    sdr_width = 2'b10;
    start_req("t6c", 26'h0C0, 9'd100, 1'b1, 1'b0, 4'h8);
    chunk("t6c1", 2'd0, 13'd0, 13'h0C0, 11'd64, 1'b1, 1'b0);
    chk("t6c.c2len", 32'(bus.r2b_len), 32'd256);
    reset_n = 1'b0;
    #1 chk("t6c.rst_req", 32'(bus.r2b_req), 32'd0);
    chk("t6c.rst_len", 32'(bus.r2b_len), 32'd0);
    chk("t6c.rst_ba",  32'(bus.r2b_ba),  32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t6c.no_c3", 32'(bus.r2b_req), 32'd0);
    chk("t6c.idle", 32'(bus.r2x_idle), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
